// File: rtl/tilling_buffer_ctrl.sv
// Sequencer for the 4-quadrant tiling buffer: fills quadrant pairs {0,2}
// then {1,3}, presents the tile downstream and releases the sub-buffers.
module tilling_buffer_ctrl #(
  parameter int SIZE_OF_BUFFER = 8,
  parameter int TILE_CNT_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  abort_i,
  output logic [3:0]            buf_wr_en_o,
  output logic                  buf_rd_en_o,
  input  logic [3:0]            buf_is_empty_i,
  input  logic [3:0]            buf_is_full_i,
  output logic                  tile_valid_o,
  input  logic                  tile_ready_i,
  output logic [TILE_CNT_W-1:0] tile_cnt_o,
  output logic                  err_o
);

  localparam int HALF = SIZE_OF_BUFFER / 2;
  localparam int RW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [2:0] {
    WAIT_EMPTY,
    FILL_TOP,
    FILL_BOT,
    WAIT_FULL,
    PRESENT,
    DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         row_cnt_q, row_cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  tile_valid_q, tile_valid_d;
  logic                  rd_en_q, rd_en_d;
  logic [TILE_CNT_W-1:0] tile_cnt_q, tile_cnt_d;
  logic                  err_q, err_d;
  logic                  wd_arm_q, wd_arm_d;
  logic [1:0]            wd_cnt_q, wd_cnt_d;

  logic wr_fire;
  logic row_last;
  logic wd_trip;

  assign wr_fire  = in_valid_i & in_ready_q & ~abort_i;
  assign row_last = (row_cnt_q == RW'(HALF - 1));

  always_comb begin
    buf_wr_en_o = 4'b0000;
    if (wr_fire) begin
      if (state_q == FILL_TOP) buf_wr_en_o = 4'b0101;
      if (state_q == FILL_BOT) buf_wr_en_o = 4'b1010;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    tile_cnt_d = tile_cnt_q;
    case (state_q)
      WAIT_EMPTY: begin
        if (buf_is_empty_i == 4'hF) begin
          state_d   = FILL_TOP;
          row_cnt_d = '0;
        end
      end
      FILL_TOP: begin
        if (wr_fire) begin
          if (row_last) begin
            state_d   = FILL_BOT;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + RW'(1);
          end
        end
      end
      FILL_BOT: begin
        if (wr_fire) begin
          if (row_last) begin
            state_d   = WAIT_FULL;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + RW'(1);
          end
        end
      end
      WAIT_FULL: begin
        if (buf_is_full_i == 4'hF) state_d = PRESENT;
      end
      PRESENT: begin
        if (tile_valid_q & tile_ready_i) begin
          state_d    = DRAIN;
          tile_cnt_d = tile_cnt_q + TILE_CNT_W'(1);
        end
      end
      DRAIN:   state_d = WAIT_EMPTY;
      default: state_d = WAIT_EMPTY;
    endcase
    // Abort discards everything in flight, including a same-cycle accept.
    if (abort_i) begin
      state_d    = DRAIN;
      row_cnt_d  = '0;
      tile_cnt_d = tile_cnt_q;
    end
  end

  always_comb begin
    in_ready_d   = (state_d == FILL_TOP) | (state_d == FILL_BOT);
    tile_valid_d = (state_d == PRESENT);
    rd_en_d      = (state_d == DRAIN);
  end

  // Watchdog: a top-pair write must clear the empty flags within 2 cycles.
  always_comb begin
    wd_arm_d = wd_arm_q;
    wd_cnt_d = wd_cnt_q;
    wd_trip  = 1'b0;
    if (wr_fire && state_q == FILL_TOP) begin
      wd_arm_d = 1'b1;
      wd_cnt_d = 2'd0;
    end else if (wd_arm_q) begin
      if (buf_is_empty_i != 4'hF) begin
        wd_arm_d = 1'b0;
      end else if (wd_cnt_q == 2'd2) begin
        wd_trip  = 1'b1;
        wd_arm_d = 1'b0;
      end else begin
        wd_cnt_d = wd_cnt_q + 2'd1;
      end
    end
  end

  always_comb begin
    err_d = err_q | wd_trip |
            (wr_fire & (|(buf_wr_en_o & buf_is_full_i)));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= WAIT_EMPTY;
      row_cnt_q    <= '0;
      in_ready_q   <= 1'b0;
      tile_valid_q <= 1'b0;
      rd_en_q      <= 1'b0;
      tile_cnt_q   <= '0;
      err_q        <= 1'b0;
      wd_arm_q     <= 1'b0;
      wd_cnt_q     <= 2'd0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      in_ready_q   <= in_ready_d;
      tile_valid_q <= tile_valid_d;
      rd_en_q      <= rd_en_d;
      tile_cnt_q   <= tile_cnt_d;
      err_q        <= err_d;
      wd_arm_q     <= wd_arm_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign tile_valid_o = tile_valid_q;
  assign buf_rd_en_o  = rd_en_q;
  assign tile_cnt_o   = tile_cnt_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_tilling_buffer_ctrl.sv
// Randomised and directed bench for tilling_buffer_ctrl with a word-count
// reference model and a quadrant-occupancy buffer model.
module tb_tilling_buffer_ctrl;

  localparam int SZ   = 8;
  localparam int HALF = SZ / 2;
  localparam int CW   = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic          abort_i = 1'b0;
  logic [3:0]    buf_wr_en_o;
  logic          buf_rd_en_o;
  logic [3:0]    buf_is_empty_i;
  logic [3:0]    buf_is_full_i;
  logic          tile_valid_o;
  logic          tile_ready_i = 1'b0;
  logic [CW-1:0] tile_cnt_o;
  logic          err_o;

  tilling_buffer_ctrl #(.SIZE_OF_BUFFER(SZ), .TILE_CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .abort_i(abort_i),
    .buf_wr_en_o(buf_wr_en_o), .buf_rd_en_o(buf_rd_en_o),
    .buf_is_empty_i(buf_is_empty_i), .buf_is_full_i(buf_is_full_i),
    .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
    .tile_cnt_o(tile_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Buffer model: words held per quadrant, flushed on release.
  int   bcnt [4] = '{0, 0, 0, 0};
  logic force_full0 = 1'b0;
  logic stuck_empty = 1'b0;
  logic flush = 1'b0;

  always_comb begin
    buf_is_empty_i = 4'h0;
    buf_is_full_i  = 4'h0;
    for (int q = 0; q < 4; q++) begin
      buf_is_empty_i[q] = stuck_empty || (bcnt[q] == 0);
      buf_is_full_i[q]  = (bcnt[q] >= HALF) || (q == 0 && force_full0);
    end
  end

  always @(posedge clk_i) begin
    for (int q = 0; q < 4; q++) begin
      if (buf_rd_en_o || flush) bcnt[q] <= 0;
      else if (buf_wr_en_o[q] && bcnt[q] < HALF) bcnt[q] <= bcnt[q] + 1;
    end
  end

  // Reference model: tile progress measured in words accepted.
  typedef enum int {M_EMPTY, M_FILL, M_FULL, M_PRES, M_DRAIN} mode_t;
  mode_t m = M_EMPTY;
  int    words = 0;
  int    tiles = 0;
  int    since = -1;
  bit    e_err = 1'b0;

  function automatic logic [3:0] pat_now();
    return (words < HALF) ? 4'b0101 : 4'b1010;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m = M_EMPTY; words = 0; tiles = 0; e_err = 1'b0; since = -1;
    end else begin
      bit fire;
      logic [3:0] pat;
      pat  = pat_now();
      fire = (m == M_FILL) && in_valid_i && !abort_i;
      if (fire && ((pat & buf_is_full_i) != 4'h0)) e_err = 1'b1;
      if (fire && words < HALF) since = 0;
      else if (since >= 0) begin
        if (buf_is_empty_i != 4'hF) since = -1;
        else begin
          since++;
          if (since > 2) begin e_err = 1'b1; since = -1; end
        end
      end
      if (abort_i) begin
        m = M_DRAIN; words = 0;
      end else begin
        case (m)
          M_EMPTY: if (buf_is_empty_i == 4'hF) begin m = M_FILL; words = 0; end
          M_FILL:  if (fire) begin
                     words++;
                     if (words == SZ) m = M_FULL;
                   end
          M_FULL:  if (buf_is_full_i == 4'hF) m = M_PRES;
          M_PRES:  if (tile_ready_i) begin
                     tiles = (tiles + 1) % (1 << CW);
                     m = M_DRAIN;
                   end
          default: m = M_EMPTY;
        endcase
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk_i) begin
    logic [3:0] ewr;
    ewr = (m == M_FILL && in_valid_i && !abort_i) ? pat_now() : 4'h0;
    chk("in_ready", in_ready_o, (m == M_FILL));
    chk("tile_valid", tile_valid_o, (m == M_PRES));
    chk("rd_en", buf_rd_en_o, (m == M_DRAIN));
    chk("wr_en", buf_wr_en_o, ewr);
    chk("tile_cnt", tile_cnt_o, tiles);
    chk("err", err_o, e_err);
  end

  // Event monitor for the directed scenarios.
  logic [3:0] wq[$];
  int nrd = 0;
  int nvalid = 0;
  int bad_wr = 0;

  always @(negedge clk_i) begin
    if (buf_wr_en_o != 4'h0) begin
      wq.push_back(buf_wr_en_o);
      if (!in_valid_i) bad_wr++;
    end
    if (buf_rd_en_o) nrd++;
    if (tile_valid_o) nvalid++;
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_tile();
    int n0, k;
    n0 = nrd; k = 0;
    while (nrd == n0 && k < 80) begin cyc(); k++; end
    chk("tile_timeout", (nrd != n0), 1);
  endtask

  task automatic check_pairs(input string n);
    chk({n, "_count"}, wq.size(), 8);
    for (int i = 0; i < 8; i++)
      chk({n, "_pat"}, (i < wq.size()) ? wq[i] : 4'h0,
          (i < 4) ? 4'b0101 : 4'b1010);
  endtask

  initial begin
    int k;
    // 1: reset values, then one full tile with everything flowing
    in_valid_i = 1'b1; tile_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_valid", tile_valid_o, 0);
    chk("rst_rd", buf_rd_en_o, 0);
    chk("rst_wr", buf_wr_en_o, 0);
    chk("rst_cnt", tile_cnt_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;
    wq.delete(); nrd = 0; nvalid = 0;
    wait_tile();
    check_pairs("t1");
    chk("t1_rd", nrd, 1);
    chk("t1_valid_seen", (nvalid != 0), 1);
    chk("t1_cnt", tile_cnt_o, 1);

    // 2: downstream stall in PRESENT
    tile_ready_i = 1'b0;
    k = 0;
    while (!tile_valid_o && k < 40) begin cyc(); k++; end
    chk("t2_valid", tile_valid_o, 1);
    repeat (10) begin
      cyc();
      chk("t2_hold_valid", tile_valid_o, 1);
      chk("t2_hold_ready", in_ready_o, 0);
      chk("t2_hold_wr", buf_wr_en_o, 0);
      chk("t2_hold_rd", buf_rd_en_o, 0);
    end
    tile_ready_i = 1'b1;
    cyc();
    chk("t2_drain", buf_rd_en_o, 1);
    chk("t2_cnt", tile_cnt_o, 2);
    cyc();

    // 3: toggling word valid
    wq.delete(); bad_wr = 0;
    begin
      int n0;
      n0 = nrd; k = 0;
      while (nrd == n0 && k < 80) begin
        in_valid_i = ~in_valid_i;
        cyc(); k++;
      end
      chk("t3_timeout", (nrd != n0), 1);
    end
    check_pairs("t3");
    chk("t3_bad_wr", bad_wr, 0);
    chk("t3_cnt", tile_cnt_o, 3);

    // 4: abort with the 6th word
    in_valid_i = 1'b1;
    wq.delete();
    k = 0;
    while (wq.size() < 5 && k < 40) begin cyc(); k++; end
    chk("t4_five", wq.size(), 5);
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    chk("t4_dropped", wq.size(), 5);
    chk("t4_rd", buf_rd_en_o, 1);
    chk("t4_cnt", tile_cnt_o, 3);
    wq.delete();
    k = 0;
    while (wq.size() < 4 && k < 40) begin cyc(); k++; end
    chk("t4_restart_n", wq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t4_restart_top", (i < wq.size()) ? wq[i] : 4'h0, 4'b0101);
    wait_tile();
    chk("t4_cnt_after", tile_cnt_o, 4);

    // randomised traffic with occasional aborts
    for (int c = 0; c < 1500; c++) begin
      in_valid_i   = ($urandom_range(0, 3) != 0);
      tile_ready_i = ($urandom_range(0, 2) != 0);
      abort_i      = ($urandom_range(0, 40) == 0);
      cyc();
    end
    abort_i = 1'b0; in_valid_i = 1'b1; tile_ready_i = 1'b1;

    // 5: full flag seen during a top-pair write
    k = 0;
    while (!(m == M_FILL && words < HALF) && k < 40) begin cyc(); k++; end
    chk("t5_no_err_yet", err_o, 0);
    force_full0 = 1'b1;
    cyc();
    force_full0 = 1'b0;
    chk("t5_err", err_o, 1);
    wait_tile();
    wait_tile();
    chk("t5_err_sticky", err_o, 1);

    // 6: asynchronous reset mid bottom fill
    k = 0;
    while (!(m == M_FILL && words == HALF + 1) && k < 40) begin cyc(); k++; end
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_ready", in_ready_o, 0);
    chk("t6_wr", buf_wr_en_o, 0);
    chk("t6_valid", tile_valid_o, 0);
    chk("t6_rd", buf_rd_en_o, 0);
    chk("t6_cnt", tile_cnt_o, 0);
    chk("t6_err", err_o, 0);
    cyc();
    rst_i = 1'b0;
    repeat (5) begin
      cyc();
      chk("t6_wait_empty", in_ready_o, 0);
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    chk("t6_fill", in_ready_o, 1);

    // 7: counter wrap (shortened-width build)
    for (int t = 0; t < 15; t++) wait_tile();
    chk("t7_max", tile_cnt_o, 4'hF);
    wait_tile();
    chk("t7_wrap", tile_cnt_o, 0);

    // empty flags that never react to top-pair writes
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    in_valid_i = 1'b0;
    flush = 1'b1;
    stuck_empty = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
    flush = 1'b0;
    cyc();
    chk("t8_fill", in_ready_o, 1);
    chk("t8_no_err", err_o, 0);
    in_valid_i = 1'b1;
    cyc();
    in_valid_i = 1'b0;
    repeat (4) cyc();
    chk("t8_err", err_o, 1);
    stuck_empty = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
